midi_uart_rx: RTL and testbench

Serial front end of the MIDI input path. It oversamples the opto-isolated MIDI line at the system clock and deframes 31250-baud 8N1 characters. It presents each valid byte on `midiByte` with a stretched `midiReady` strobe for the MIDI message parser directly downstream. Real-time bytes (0xF8–0xFF) are optionally dropped, because the parser's command/data state machine does not tolerate bytes interleaved mid-message.

---
 rtl/midi_uart_rx.sv | 150 +++++++++++++++
 tb/tb_midi_uart_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: synchronizes the raw line, deframes 8N1 characters and presents
// each accepted byte with a fixed-width ready pulse for the downstream message parser.
module midi_uart_rx #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 31250,
    parameter int unsigned READY_CYCLES = 16,
    parameter int unsigned FILTER_RT    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] midi_byte_o,
    output logic       midi_ready_o,
    output logic       frame_error_o
);

    localparam int unsigned Bit  = CLK_HZ / BAUD;
    localparam int unsigned Half = Bit / 2;
    localparam int unsigned TW   = $clog2(Bit + 1);

    localparam logic [TW-1:0] HalfM1  = TW'(Half - 1);
    localparam logic [TW-1:0] BitM1   = TW'(Bit - 1);
    localparam logic [TW-1:0] ReadyM1 = TW'(READY_CYCLES - 1);

    if (READY_CYCLES < 2 || READY_CYCLES > Bit) begin : g_bad_ready
        $error("READY_CYCLES must lie in 2..CLK_HZ/BAUD");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e        state_q;
    logic [1:0]    sync_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          load_q;
    logic          ready_start_q;
    logic          ready_q;
    logic [TW-1:0] ready_cnt_q;
    logic [7:0]    midi_byte_q;
    logic          frame_error_q;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Deframing FSM; timer restarts at every sample point so each wait is a plain compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            load_q        <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            load_q        <= 1'b0;
            frame_error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        timer_q <= '0;
                    end
                end
                StStart: begin
                    if (timer_q == HalfM1) begin
                        timer_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StData: begin
                    if (timer_q == BitM1) begin
                        timer_q <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StStop: begin
                    if (timer_q == BitM1) begin
                        timer_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                            load_q  <= !((FILTER_RT != 0) && (&shift_q[7:3]));
                        end else begin
                            state_q       <= StBreak;
                            frame_error_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Byte loads one clock before ready rises so the parser sees a settled value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            midi_byte_q   <= 8'h00;
            ready_start_q <= 1'b0;
            ready_q       <= 1'b0;
            ready_cnt_q   <= '0;
        end else begin
            ready_start_q <= load_q;
            if (load_q) begin
                midi_byte_q <= shift_q;
            end
            if (ready_start_q) begin
                ready_q     <= 1'b1;
                ready_cnt_q <= ReadyM1;
            end else if (ready_cnt_q != '0) begin
                ready_cnt_q <= ready_cnt_q - 1'b1;
            end else begin
                ready_q <= 1'b0;
            end
        end
    end

    assign midi_byte_o   = midi_byte_q;
    assign midi_ready_o  = ready_q;
    assign frame_error_o = frame_error_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Scoreboard bench for midi_uart_rx: two instances (real-time filter on / off) share one line;
// the driver queues expected presentations and frame errors, a monitor pops and compares them.
module tb_midi_uart_rx;

    localparam int unsigned ClkHz = 320000;
    localparam int unsigned Baud  = 10000;
    localparam int B   = 32;
    localparam int H   = 16;
    localparam int RC  = 16;
    // drive edge -> sync (2) -> FSM sees low (1) -> stop sample -> byte (+1) -> ready (+1)
    localparam int LatReady = 3 + H + 9 * B + 2;
    localparam int LatFe    = 3 + H + 9 * B;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] mb [2];
    logic       mr [2];
    logic       fe [2];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   fq0[$];
    int   fq1[$];

    midi_uart_rx #(.CLK_HZ(ClkHz), .BAUD(Baud), .READY_CYCLES(RC), .FILTER_RT(1)) u_filt (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx),
        .midi_byte_o(mb[0]), .midi_ready_o(mr[0]), .frame_error_o(fe[0])
    );

    midi_uart_rx #(.CLK_HZ(ClkHz), .BAUD(Baud), .READY_CYCLES(RC), .FILTER_RT(0)) u_pass (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx),
        .midi_byte_o(mb[1]), .midi_ready_o(mr[1]), .frame_error_o(fe[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int d);
        checks++;
        failures++;
        $display("FAIL %s dut%0d at cycle %0d", name, d, cyc);
    endtask

    // Called on a negedge; drives start, 8 data bits LSB-first, and the given stop level.
    task automatic send(input logic [7:0] b, input logic stop);
        exp_t e;
        logic rt;
        rt  = (b >= 8'hF8);
        e.b = b;
        e.t = cyc + LatReady;
        if (stop) begin
            if (!rt) q0.push_back(e);
            q1.push_back(e);
        end else begin
            fq0.push_back(cyc + LatFe);
            fq1.push_back(cyc + LatFe);
        end
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop;
        repeat (B) @(negedge clk);
    endtask

    logic       mr_prev [2] = '{1'b0, 1'b0};
    logic       fe_prev [2] = '{1'b0, 1'b0};
    logic [7:0] mb_prev [2] = '{8'h00, 8'h00};
    int         hi [2] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            int   ft;
            bit   have;
            if (mr[d] && !mr_prev[d]) begin
                have = 1'b0;
                if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    flag("unexpected_ready", d);
                end else begin
                    check("byte", d, int'(mb[d]), int'(e.b));
                    check("rise_time", d, cyc, e.t);
                    check("byte_setup", d, int'(mb_prev[d]), int'(e.b));
                end
                hi[d] = 1;
            end else if (mr[d]) begin
                hi[d]++;
            end else if (mr_prev[d]) begin
                check("ready_width", d, hi[d], RC);
            end
            if (fe[d] && fe_prev[d]) flag("frame_error_width", d);
            if (fe[d] && !fe_prev[d]) begin
                have = 1'b0;
                if (d == 0 && fq0.size() != 0) begin ft = fq0.pop_front(); have = 1'b1; end
                if (d == 1 && fq1.size() != 0) begin ft = fq1.pop_front(); have = 1'b1; end
                if (!have) flag("unexpected_frame_error", d);
                else check("frame_error_time", d, cyc, ft);
            end
            mr_prev[d] = mr[d];
            fe_prev[d] = fe[d];
            mb_prev[d] = mb[d];
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_byte", d, int'(mb[d]), 0);
            check("reset_ready", d, int'(mr[d]), 0);
            check("reset_frame_error", d, int'(fe[d]), 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h90, 1'b1);
        repeat (2 * B) @(negedge clk);

        send(8'h90, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h64, 1'b1);
        repeat (2 * B) @(negedge clk);

        // Low glitch shorter than half a bit must be rejected; the next byte proves IDLE.
        rx = 1'b0;
        repeat (H / 2) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        send(8'h01, 1'b1);
        repeat (2 * B) @(negedge clk);

        send(8'h45, 1'b0);
        repeat (5 * B) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        send(8'h80, 1'b1);
        repeat (2 * B) @(negedge clk);

        send(8'hF8, 1'b1);
        send(8'hFE, 1'b1);
        send(8'h90, 1'b1);
        repeat (2 * B) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xAA.
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 1);
            repeat (B) @(negedge clk);
        end
        rx = 1'b0;
        repeat (B / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midreset_byte", d, int'(mb[d]), 0);
            check("midreset_ready", d, int'(mr[d]), 0);
            check("midreset_frame_error", d, int'(fe[d]), 0);
        end
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * B) @(negedge clk);
        send(8'h3C, 1'b1);
        repeat (2 * B + 2 * RC) @(negedge clk);

        check("pending_ready", 0, q0.size(), 0);
        check("pending_ready", 1, q1.size(), 0);
        check("pending_frame_error", 0, fq0.size(), 0);
        check("pending_frame_error", 1, fq1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
